// File: rtl/mpc_mul_share_arbiter_if.sv
// Requester issue and tagged result buses of the shared MPC multiplier arbiter.
// The arbiter is the slave; the requester/consumer side is the master.
interface mpc_mul_share_arbiter_if #(
  parameter int N     = 3,
  parameter int TAG_W = 2
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*21-1:0]     req_a;
  logic [N*14-1:0]     req_b;
  logic                res_valid;
  logic                res_ready;
  logic [TAG_W-1:0]    res_tag;
  logic signed [34:0]  res_p;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_tag, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_tag, res_p
  );
endinterface

// File: rtl/mpc_mul_share_arbiter.sv
// Round-robin sharing of one pipelined 21s x 14u multiplier among N requesters.
// Issue tags ride a shift register alongside the multiplier; the pipe freezes under result backpressure.
module mpc_mul_share_arbiter #(
  parameter int N       = 3,
  parameter int TAG_W   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mpc_mul_share_arbiter_if.slave bus,
  output logic                 mul_ce,
  output logic signed [20:0]   mul_a,
  output logic [13:0]          mul_b,
  input  logic signed [34:0]   mul_p,
  output logic [31:0]          done_cnt
);
  localparam int A_W = 21;
  localparam int B_W = 14;

  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   gnt;
  logic               gnt_vld;
  logic [TAG_W-1:0]   rr_next;
  logic [N-1:0]       ready_vec;
  logic [MUL_LAT-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [MUL_LAT];
  logic               res_vld;

  assign res_vld       = vld_sr[MUL_LAT-1];
  assign bus.res_valid = res_vld;
  assign bus.res_tag   = tag_sr[MUL_LAT-1];
  assign bus.res_p     = mul_p;
  assign bus.req_ready = ready_vec;

  // Round-robin grant: first valid requester scanning upward from rr_ptr
  always_comb begin
    logic [TAG_W:0]   sum;
    logic [TAG_W-1:0] idx;
    logic             hit;
    gnt     = rr_ptr;
    gnt_vld = 1'b0;
    sum     = {(TAG_W+1){1'b0}};
    idx     = {TAG_W{1'b0}};
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum     = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      idx     = (sum >= (TAG_W+1)'(N)) ? TAG_W'(sum - (TAG_W+1)'(N)) : TAG_W'(sum);
      hit     = !gnt_vld && bus.req_valid[idx];
      gnt     = hit ? idx : gnt;
      gnt_vld = gnt_vld | hit;
    end
    rr_next = (gnt == TAG_W'(N-1)) ? {TAG_W{1'b0}} : gnt + TAG_W'(1);
  end

  // Issue side: stall control, ready strobes and operand mux
  always_comb begin
    logic sel;
    mul_ce    = !(res_vld && !bus.res_ready);
    ready_vec = {N{1'b0}};
    mul_a     = 21'sd0;
    mul_b     = 14'd0;
    sel       = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel          = gnt_vld && (gnt == TAG_W'(i));
      ready_vec[i] = sel && mul_ce;
      mul_a        = sel ? $signed(bus.req_a[A_W*i +: A_W]) : mul_a;
      mul_b        = sel ? bus.req_b[B_W*i +: B_W] : mul_b;
    end
  end

  // Validity/tag tracking through the multiplier latency plus pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= {TAG_W{1'b0}};
      vld_sr <= {MUL_LAT{1'b0}};
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_sr[k] <= {TAG_W{1'b0}};
      end
    end else if (mul_ce) begin
      vld_sr    <= {vld_sr[MUL_LAT-2:0], gnt_vld};
      tag_sr[0] <= gnt;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_sr[k] <= tag_sr[k-1];
      end
      rr_ptr <= gnt_vld ? rr_next : rr_ptr;
    end
  end

  // Completed handoff counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= 32'd0;
    end else if (res_vld && bus.res_ready) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_mpc_mul_share_arbiter.sv
// Directed bench for mpc_mul_share_arbiter with a behavioural 3-stage multiplier
// and a tag/product scoreboard filled at issue handshakes and drained at result handoffs.
module tb_mpc_mul_share_arbiter;
  logic               clk = 1'b0;
  logic               rst;
  logic               mul_ce;
  logic signed [20:0] mul_a;
  logic [13:0]        mul_b;
  logic signed [34:0] mul_p;
  logic [31:0]        done_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]         tag;
    logic signed [34:0] p;
  } sb_item_t;
  sb_item_t sb[$];

  mpc_mul_share_arbiter_if #(.N(3), .TAG_W(2)) bus ();

  mpc_mul_share_arbiter #(.N(3), .TAG_W(2), .MUL_LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mul_ce   (mul_ce),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // Shared DSP: operand reg, product reg, output reg, all gated by mul_ce
  logic signed [20:0] ma_r;
  logic [13:0]        mb_r;
  logic signed [34:0] mp_r;
  logic signed [34:0] mo_r;
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      ma_r <= mul_a;
      mb_r <= mul_b;
      mp_r <= 35'(ma_r) * 35'($signed({1'b0, mb_r}));
      mo_r <= mp_r;
    end
  end
  assign mul_p = mo_r;

  function automatic logic signed [34:0] ref_prod(logic [20:0] a, logic [13:0] b);
    longint sa;
    longint ub;
    sa = longint'($signed(a));
    ub = longint'({50'd0, b});
    return 35'(sa * ub);
  endfunction

  task automatic check(string name, logic signed [63:0] obs, logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic set_req(int i, logic [20:0] a, logic [13:0] b);
    bus.req_a[21*i +: 21] = a;
    bus.req_b[14*i +: 14] = b;
  endtask

  task automatic monitor();
    sb_item_t it;
    for (int i = 0; i < 3; i++) begin
      if (bus.req_ready[i]) begin
        it.tag = 2'(i);
        it.p   = ref_prod(bus.req_a[21*i +: 21], bus.req_b[14*i +: 14]);
        sb.push_back(it);
      end
    end
    if (bus.res_valid && bus.res_ready) begin
      check("sb_expected_result", 64'(sb.size() != 0), 64'sd1);
      if (sb.size() != 0) begin
        it = sb.pop_front();
        check("sb_tag", 64'(bus.res_tag), 64'(it.tag));
        check("sb_p", 64'($signed(bus.res_p)), 64'(it.p));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 3'b000;
    settle();
    adv();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 3'b000;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b1;
    adv();
    adv();
    settle();
    check("rst_res_valid", 64'(bus.res_valid), 64'sd0);
    check("rst_mul_ce", 64'(mul_ce), 64'sd1);
    check("rst_req_ready", 64'(bus.req_ready), 64'sd0);
    check("rst_done_cnt", 64'(done_cnt), 64'sd0);
    adv();
    rst = 1'b0;

    // T1 single op
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c == 0) ? 3'b001 : 3'b000;
      if (c == 0) set_req(0, -21'sd5, 14'd3);
      settle();
      if (c == 0) check("t1_ready", 64'(bus.req_ready), 64'sd1);
      if (c == 1 || c == 2) check("t1_no_res", 64'(bus.res_valid), 64'sd0);
      if (c == 3) begin
        check("t1_res_valid", 64'(bus.res_valid), 64'sd1);
        check("t1_tag", 64'(bus.res_tag), 64'sd0);
        check("t1_p", 64'($signed(bus.res_p)), -64'sd15);
      end
      if (c == 4) check("t1_done_cnt", 64'(done_cnt), 64'sd1);
      adv();
    end

    // T2 fairness
    do_reset();
    set_req(0, 21'sd100, 14'd7);
    set_req(1, -21'sd200, 14'd9);
    set_req(2, 21'sd3000, 14'd11);
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 6) ? 3'b111 : 3'b000;
      settle();
      if (c < 6) check("t2_grant", 64'(bus.req_ready), 64'(3'b001 << (c % 3)));
      if (c >= 3 && c < 9) begin
        check("t2_res_valid", 64'(bus.res_valid), 64'sd1);
        check("t2_tag_order", 64'(bus.res_tag), 64'((c - 3) % 3));
      end
      if (c == 9) check("t2_drained", 64'(bus.res_valid), 64'sd0);
      adv();
    end

    // T3 backpressure on cycles 4-6
    set_req(1, 21'sd1000, 14'd16383);
    for (int c = 0; c < 13; c++) begin
      bus.req_valid = (c <= 8) ? 3'b010 : 3'b000;
      bus.res_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      settle();
      if (c >= 4 && c <= 6) begin
        check("t3_stall_ce", 64'(mul_ce), 64'sd0);
        check("t3_stall_ready", 64'(bus.req_ready), 64'sd0);
        check("t3_stall_valid", 64'(bus.res_valid), 64'sd1);
        check("t3_stall_p", 64'($signed(bus.res_p)), 64'sd16383000);
      end else if (c <= 8) begin
        check("t3_ready", 64'(bus.req_ready), 64'sd2);
      end
      adv();
    end
    settle();
    check("t3_done_cnt", 64'(done_cnt), 64'sd12);
    adv();

    // T4 operand extremes
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        bus.req_valid = 3'b001;
        set_req(0, 21'h10_0000, 14'd16383);
      end else if (c == 1) begin
        bus.req_valid = 3'b100;
        set_req(2, 21'h0F_FFFF, 14'd16383);
      end else begin
        bus.req_valid = 3'b000;
      end
      settle();
      if (c == 0) check("t4_ready0", 64'(bus.req_ready), 64'sd1);
      if (c == 1) check("t4_ready2", 64'(bus.req_ready), 64'sd4);
      if (c == 3) check("t4_p_min", 64'($signed(bus.res_p)), -64'sd17178820608);
      if (c == 4) check("t4_p_max", 64'($signed(bus.res_p)), 64'sd17178804225);
      adv();
    end

    // T6 sparse requesters and bubbles
    set_req(2, 21'sd77, 14'd5);
    set_req(0, -21'sd9, 14'd100);
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = (c == 0) ? 3'b100 : ((c == 2) ? 3'b001 : 3'b000);
      settle();
      if (c == 0) check("t6_ready2", 64'(bus.req_ready), 64'sd4);
      if (c == 2) check("t6_ready0", 64'(bus.req_ready), 64'sd1);
      if (c == 3 || c == 5) check("t6_res_valid", 64'(bus.res_valid), 64'sd1);
      if (c == 3) check("t6_tag2", 64'(bus.res_tag), 64'sd2);
      if (c == 5) check("t6_tag0", 64'(bus.res_tag), 64'sd0);
      if (c == 4 || c == 6) check("t6_bubble", 64'(bus.res_valid), 64'sd0);
      if (c == 6) check("t6_done_cnt", 64'(done_cnt), 64'sd16);
      adv();
    end

    // T5 reset while operations are in flight
    set_req(1, 21'sd11, 14'd2);
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 3'b010;
      rst = (c == 2) ? 1'b1 : 1'b0;
      settle();
      if (c < 2) check("t5_issue", 64'(bus.req_ready), 64'sd2);
      adv();
    end
    rst = 1'b0;
    bus.req_valid = 3'b000;
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t5_no_res", 64'(bus.res_valid), 64'sd0);
      if (c == 0) check("t5_done_cnt", 64'(done_cnt), 64'sd0);
      adv();
    end
    set_req(0, 21'sd4, 14'd4);
    set_req(2, 21'sd6, 14'd6);
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c == 0) ? 3'b111 : 3'b000;
      settle();
      if (c == 0) check("t5_rr_ptr0", 64'(bus.req_ready), 64'sd1);
      if (c == 3) check("t5_post_res", 64'(bus.res_valid), 64'sd1);
      adv();
    end
    settle();
    check("final_sb_empty", 64'(sb.size()), 64'sd0);
    check("final_done_cnt", 64'(done_cnt), 64'sd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
